// File: rtl/gpin_pkg.sv
// Shared constants and width helpers for the GPIO input conditioner.
// No logic; sizes the prescaler and the per-bit debounce counter.
package gpin_pkg;

    localparam int GPIN_WIDTH      = 32;
    localparam int GPIN_TICK_DIV   = 4;
    localparam int GPIN_DB_SAMPLES = 3;

    function automatic int gpin_cnt_width(input int db_samples);
        return $clog2(db_samples + 1);
    endfunction

    // A divide-by-1 prescaler still needs one flop so the vector is never zero-width.
    function automatic int gpin_presc_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Raw input / event-clear / conditioned-output bundle for gpio_in_conditioner.
// master drives raw_in and the clear strobe; slave produces level and event words.
interface gpio_in_conditioner_if
    import gpin_pkg::*;
#(
    parameter int WIDTH = GPIN_WIDTH
);
    logic [WIDTH-1:0] raw_in;
    logic             clr_we;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] event_out;
    logic             any_event;

    modport master (
        output raw_in, clr_we, clr_mask,
        input  level_out, event_out, any_event
    );

    modport slave (
        input  raw_in, clr_we, clr_mask,
        output level_out, event_out, any_event
    );
endinterface

// File: rtl/gpin_debounce_bit.sv
// One input bit: 2-flop synchroniser, tick-driven debounce counter, level register.
// Latency 2 cycles sync + DB_SAMPLES ticks + 1; no backpressure, level is free-running.
// rise/fall are combinational from the next-state of level, aligned with its update edge.
module gpin_debounce_bit
    import gpin_pkg::*;
#(
    parameter int DB_SAMPLES = GPIN_DB_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int            CW       = gpin_cnt_width(DB_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;

    // Any matching sample restarts the run; only DB_SAMPLES differing ticks in a row flip level.
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        if (tick) begin
            if (sync_q2 == level) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                level_nxt = sync_q2;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            cnt     <= cnt_nxt;
            level   <= level_nxt;
        end
    end

    assign rise = ~level &  level_nxt;
    assign fall =  level & ~level_nxt;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronise, debounce and edge-capture WIDTH raw inputs; sticky events cleared by masked write.
// Latency DB_SAMPLES*TICK_DIV-TICK_DIV+3 .. DB_SAMPLES*TICK_DIV+2 cycles; no backpressure.
// GPIN_BOTH_EDGES_EN: when defined, falling edges also set event bits.
module gpio_in_conditioner
    import gpin_pkg::*;
#(
    parameter int WIDTH      = GPIN_WIDTH,
    parameter int TICK_DIV   = GPIN_TICK_DIV,
    parameter int DB_SAMPLES = GPIN_DB_SAMPLES
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_in_conditioner_if.slave bus
);
    localparam int PW = gpin_presc_width(TICK_DIV);

    logic [PW-1:0]    presc;
    logic             tick;
    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] event_q;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpin_debounce_bit #(
            .DB_SAMPLES(DB_SAMPLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.raw_in[i]),
            .tick (tick),
            .level(level_w[i]),
            .rise (rise_w[i]),
            .fall (fall_w[i])
        );
    end

`ifdef GPIN_BOTH_EDGES_EN
    assign set_vec = rise_w | fall_w;
`else
    logic unused_fall;
    assign unused_fall = ^fall_w;
    assign set_vec     = rise_w;
`endif

    assign clr_vec = bus.clr_we ? bus.clr_mask : '0;

    // Set is ORed in after the clear so an edge landing on a clear cycle is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            event_q <= '0;
        end else begin
            event_q <= (event_q & ~clr_vec) | set_vec;
        end
    end

    assign bus.level_out = level_w;
    assign bus.event_out = event_q;
    assign bus.any_event = |event_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner: expected level/event words queued at stimulus,
// popped when level_out changes. Inputs driven and outputs sampled on the falling edge.
module tb_gpio_in_conditioner;
    import gpin_pkg::*;

    typedef struct packed {
        logic [31:0] lvl;
        logic [31:0] evt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [31:0] exp_level;
    logic [31:0] exp_event;

    gpio_in_conditioner_if #(.WIDTH(32)) bus ();

    gpio_in_conditioner #(
        .WIDTH     (32),
        .TICK_DIV  (4),
        .DB_SAMPLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after level_out changes.
    task automatic wait_level_change(input int budget, output int n, output bit hit);
        logic [31:0] old;
        old = bus.level_out;
        n   = 0;
        hit = 1'b0;
        while (n < budget && !hit) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.level_out !== old) hit = 1'b1;
        end
    endtask

    task automatic do_reset();
        bus.raw_in   = '0;
        bus.clr_we   = 1'b0;
        bus.clr_mask = '0;
        rst          = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        exp_level = '0;
        exp_event = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        int   n;
        bit   hit;
        exp_t e;
        bus.raw_in   = 32'hFFFF_FFFF;
        bus.clr_we   = 1'b0;
        bus.clr_mask = '0;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.level_out !== 32'h0) begin
            errors++; $display("FAIL reset_level: got %h want %h", bus.level_out, 32'h0);
        end
        checks++;
        if (bus.event_out !== 32'h0) begin
            errors++; $display("FAIL reset_event: got %h want %h", bus.event_out, 32'h0);
        end
        checks++;
        if (bus.any_event !== 1'b0) begin
            errors++; $display("FAIL reset_any: got %b want 0", bus.any_event);
        end
        exp_q.push_back('{lvl: 32'hFFFF_FFFF, evt: 32'hFFFF_FFFF});
        rst = 1'b1;
        wait_level_change(20, n, hit);
        checks++;
        if (!hit || n > 14) begin
            errors++; $display("FAIL reset_release_latency: got %0d cycles (hit=%0b) want <=14", n, hit);
        end
        if (hit && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.level_out !== e.lvl) begin
                errors++; $display("FAIL reset_release_level: got %h want %h", bus.level_out, e.lvl);
            end
            checks++;
            if (bus.event_out !== e.evt) begin
                errors++; $display("FAIL reset_release_event: got %h want %h", bus.event_out, e.evt);
            end
            checks++;
            if (bus.any_event !== 1'b1) begin
                errors++; $display("FAIL reset_release_any: got %b want 1", bus.any_event);
            end
        end
    endtask

    // Rise on bit 0, then bits 8..10, each launched at a random prescaler phase.
    task automatic test_clean_rise();
        int   n;
        bit   hit;
        int   b;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 0 : 7 + k;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp_level = exp_level | (32'd1 << b);
            exp_event = exp_event | (32'd1 << b);
            exp_q.push_back('{lvl: exp_level, evt: exp_event});
            bus.raw_in = bus.raw_in | (32'd1 << b);
            wait_level_change(20, n, hit);
            checks++;
            if (!hit || n < 11 || n > 14) begin
                errors++; $display("FAIL rise_latency bit %0d: got %0d cycles (hit=%0b) want 11..14", b, n, hit);
            end
            if (hit && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.level_out !== e.lvl) begin
                    errors++; $display("FAIL rise_level bit %0d: got %h want %h", b, bus.level_out, e.lvl);
                end
                checks++;
                if (bus.event_out !== e.evt) begin
                    errors++; $display("FAIL rise_event bit %0d: got %h want %h", b, bus.event_out, e.evt);
                end
                checks++;
                if (bus.any_event !== 1'b1) begin
                    errors++; $display("FAIL rise_any bit %0d: got %b want 1", b, bus.any_event);
                end
            end
        end
    endtask

    task automatic test_glitch();
        bus.raw_in[5] = 1'b1;
        repeat (6) @(negedge clk);
        bus.raw_in[5] = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (bus.level_out !== exp_level) begin
            errors++; $display("FAIL glitch_level: got %h want %h", bus.level_out, exp_level);
        end
        checks++;
        if (bus.event_out !== exp_event) begin
            errors++; $display("FAIL glitch_event: got %h want %h", bus.event_out, exp_event);
        end
    endtask

    task automatic test_clear();
        int   n;
        bit   hit;
        exp_t e;
        bus.clr_we   = 1'b0;
        bus.clr_mask = 32'h1;
        @(negedge clk);
        checks++;
        if (bus.event_out !== exp_event) begin
            errors++; $display("FAIL clear_no_we: got %h want %h", bus.event_out, exp_event);
        end
        bus.clr_we = 1'b1;
        @(negedge clk);
        bus.clr_we   = 1'b0;
        bus.clr_mask = '0;
        exp_event    = exp_event & ~32'h1;
        checks++;
        if (bus.event_out !== exp_event) begin
            errors++; $display("FAIL clear_bit0: got %h want %h", bus.event_out, exp_event);
        end
        // Clear of bit 2 held throughout the debounce so it overlaps the rising edge.
        bus.clr_we    = 1'b1;
        bus.clr_mask  = 32'h4;
        bus.raw_in[2] = 1'b1;
        exp_level     = exp_level | 32'h4;
        exp_event     = exp_event | 32'h4;
        exp_q.push_back('{lvl: exp_level, evt: exp_event});
        wait_level_change(20, n, hit);
        bus.clr_we   = 1'b0;
        bus.clr_mask = '0;
        checks++;
        if (!hit) begin
            errors++; $display("FAIL collision_timeout: got no level change in %0d cycles want one", n);
        end
        if (hit && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.level_out !== e.lvl) begin
                errors++; $display("FAIL collision_level: got %h want %h", bus.level_out, e.lvl);
            end
            checks++;
            if (bus.event_out !== e.evt) begin
                errors++; $display("FAIL collision_event: got %h want %h", bus.event_out, e.evt);
            end
        end
    endtask

    task automatic test_fall();
        int   n;
        bit   hit;
        exp_t e;
        bus.raw_in[0] = 1'b0;
        exp_level     = exp_level & ~32'h1;
`ifdef GPIN_BOTH_EDGES_EN
        exp_event     = exp_event | 32'h1;
`endif
        exp_q.push_back('{lvl: exp_level, evt: exp_event});
        wait_level_change(20, n, hit);
        checks++;
        if (!hit || n < 11 || n > 14) begin
            errors++; $display("FAIL fall_latency: got %0d cycles (hit=%0b) want 11..14", n, hit);
        end
        if (hit && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.level_out !== e.lvl) begin
                errors++; $display("FAIL fall_level: got %h want %h", bus.level_out, e.lvl);
            end
            checks++;
            if (bus.event_out !== e.evt) begin
                errors++; $display("FAIL fall_event: got %h want %h", bus.event_out, e.evt);
            end
        end
    endtask

    // After reset the synchroniser and prescaler start from zero, so the rise lands on edge 12.
    task automatic test_mid_reset();
        int   n;
        bit   hit;
        exp_t e;
        do_reset();
        @(negedge clk);
        bus.raw_in = 32'h80;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level_out !== 32'h0) begin
            errors++; $display("FAIL midreset_level: got %h want %h", bus.level_out, 32'h0);
        end
        checks++;
        if (bus.event_out !== 32'h0) begin
            errors++; $display("FAIL midreset_event: got %h want %h", bus.event_out, 32'h0);
        end
        checks++;
        if (bus.any_event !== 1'b0) begin
            errors++; $display("FAIL midreset_any: got %b want 0", bus.any_event);
        end
        rst = 1'b1;
        exp_q.push_back('{lvl: 32'h80, evt: 32'h80});
        wait_level_change(20, n, hit);
        checks++;
        if (!hit || n != 12) begin
            errors++; $display("FAIL midreset_latency: got %0d cycles (hit=%0b) want 12", n, hit);
        end
        if (hit && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.level_out !== e.lvl) begin
                errors++; $display("FAIL midreset_level_after: got %h want %h", bus.level_out, e.lvl);
            end
            checks++;
            if (bus.event_out !== e.evt) begin
                errors++; $display("FAIL midreset_event_after: got %h want %h", bus.event_out, e.evt);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_level    = '0;
        exp_event    = '0;
        rst          = 1'b0;
        bus.raw_in   = '0;
        bus.clr_we   = 1'b0;
        bus.clr_mask = '0;
        test_reset();
        do_reset();
        @(negedge clk);
        test_clean_rise();
        test_glitch();
        test_clear();
        test_fall();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
Conditions raw external switch/button inputs before they reach the GPIO block's general-purpose input words.
- Each bit is synchronised into clk, then debounced against a shared sample strobe.
- Rising edges are captured into sticky event bits that software clears through a masked write.
- level_out drives the GPIO block's first input word; event_out drives its second input word.

Parameters:
WIDTH, 32, number of input bits conditioned (1..32)
TICK_DIV, 4, clk cycles per debounce sample strobe (>=1)
DB_SAMPLES, 3, consecutive differing samples required to accept a level change (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-low reset
raw_in  input  WIDTH  asynchronous external inputs
clr_we  input  1  event clear strobe, one cycle
clr_mask  input  WIDTH  event bits to clear when clr_we=1
level_out  output  WIDTH  debounced level, registered
event_out  output  WIDTH  sticky event bits, registered
any_event  output  1  OR-reduction of event_out, combinational from registers

Behaviour:
- Reset: rst=0 sampled at a clk edge clears all state: sync flops, prescaler, per-bit counters, level_out, event_out. any_event=0. Reset has priority over every other input, including mid-debounce and mid-clear.
- Synchroniser: 2 flops per bit. sync[i] lags raw_in[i] by 2 cycles. No logic between the flops.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. tick is high in the cycle the counter equals TICK_DIV-1. With TICK_DIV=1, tick is high every cycle.
- Per-bit debounce: counter cnt, width $clog2(DB_SAMPLES+1). Acts only on tick cycles; holds its value on other cycles.
  - tick and sync[i]==level_out[i]: cnt<=0.
  - tick and sync[i]!=level_out[i] and cnt<DB_SAMPLES-1: cnt<=cnt+1.
  - tick and sync[i]!=level_out[i] and cnt==DB_SAMPLES-1: level_out[i]<=sync[i], cnt<=0.
  - Result: a level change is accepted after exactly DB_SAMPLES consecutive differing ticks. Any matching tick restarts the count.
- Latency, clean step on raw_in: 2 cycles of sync, plus a wait to the next tick, plus (DB_SAMPLES-1)*TICK_DIV cycles, plus 1 cycle to register. Range: DB_SAMPLES*TICK_DIV-TICK_DIV+3 to DB_SAMPLES*TICK_DIV+2 cycles.
- Events:
  - rise[i] = level_out[i] next-state 1 while current 0. It sets event_out[i] on the same edge that level_out[i] rises.
  - Clear: clr_we=1 clears event_out[i] for every clr_mask[i]=1 on the next edge.
  - Clear with clr_we=0 has no effect.
  - Set and clear in the same cycle on the same bit: set wins, so no event is lost.
  - Bits not selected by clr_mask are unaffected.
- Bits are independent. Simultaneous changes on several bits are each handled per the rules above.
- No handshake on outputs. The consumer samples level_out/event_out at will.

Optional Feature:
GPIN_BOTH_EDGES_EN
- Defined: event_out[i] is also set when level_out[i] falls 1->0. Set-over-clear priority is unchanged.
- Undefined: only rising edges set events. Falling edges update level_out only.

Decomposition:
- Package gpin_pkg: default constants GPIN_WIDTH=32, GPIN_TICK_DIV=4, GPIN_DB_SAMPLES=3, and a function computing the counter width.
- Sub-module gpin_debounce_bit:
  - Contains the 2-flop synchroniser, cnt, and the level register for one bit.
  - Inputs: clk, rst, raw, tick. Outputs: level, rise, fall.
  - Instantiated WIDTH times in a generate loop.
- Top level holds the prescaler, event register, clear logic and any_event.

Test Plan:
(Bench uses WIDTH=32, TICK_DIV=4, DB_SAMPLES=3 unless stated otherwise.)
1. Reset: rst=0 for 3 cycles with raw_in=32'hFFFFFFFF -> level_out=0, event_out=0, any_event=0. After rst=1, level_out=32'hFFFFFFFF within 14 cycles and event_out=32'hFFFFFFFF.
2. Clean rise: raw_in 0->32'h00000001 held -> level_out[0] rises no earlier than cycle 11 and no later than cycle 14. event_out=32'h1 on the same edge, any_event=1.
3. Glitch rejection: raw_in[5] high for 6 cycles then low -> level_out[5] stays 0, event_out[5] stays 0.
4. Clear and collision:
   - clr_we=1, clr_mask=32'h1 -> event_out[0]=0 next cycle.
   - Rise on bit 2 in the same cycle as clr_mask=32'h4 -> event_out[2]=1.
5. Fall: raw_in[0] 1->0 held -> level_out[0]=0 within 14 cycles. event_out[0] unchanged without GPIN_BOTH_EDGES_EN; event_out[0]=1 with it.
6. Mid-operation reset: rst=0 for 1 cycle during a debounce count -> all outputs 0 next edge. The count restarts, and level_out follows raw_in with full latency.
